lvds_word_align_ctrl: RTL and testbench

//  Post-lock word-alignment controller for the multi-channel LVDS receiver.

---
 rtl/lvds_word_align_ctrl_pkg.sv | 16 +
 rtl/lvds_word_align_ctrl_match.sv | 52 +++++
 rtl/lvds_word_align_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_lvds_word_align_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_word_align_ctrl_pkg.sv
// Shared types and constants for the LVDS word-alignment controller.
package lvds_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    SLIP,
    NEXT,
    DONE,
    FAIL
  } align_state_t;

  localparam logic [9:0] LVDS_DEFAULT_TRAINING_PATTERN = 10'h3E0;

endpackage

// File: rtl/lvds_word_align_ctrl_match.sv
// lvds_word_match: selects the active channel word, compares it with the
// training pattern and counts consecutive matches. The controller clears the
// count on every CHECK entry and enables counting only while in CHECK.
module lvds_word_match #(
  parameter int NUM_CHANNELS = 4,
  parameter int DESER_FACTOR = 10,
  parameter logic [DESER_FACTOR-1:0] TRAINING_PATTERN = lvds_pkg::LVDS_DEFAULT_TRAINING_PATTERN,
  parameter int MATCH_COUNT = 16
) (
  input  logic                                   clk,
  input  logic                                   usr_reset,
  input  logic                                   clear,
  input  logic                                   enable,
  input  logic [$clog2(NUM_CHANNELS)-1:0]        ch_idx,
  input  logic [NUM_CHANNELS*DESER_FACTOR-1:0]   rx_data,
  output logic                                   match,
  output logic                                   match_done
);

  localparam int CH_W = $clog2(NUM_CHANNELS);
  localparam int MC_W = $clog2(MATCH_COUNT + 1);

  logic [DESER_FACTOR-1:0] word;
  logic [MC_W-1:0]         match_cnt;

  // Pick the slice of the channel currently being aligned.
  always_comb begin
    word = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (ch_idx == CH_W'(c)) begin
        word = rx_data[c*DESER_FACTOR +: DESER_FACTOR];
      end
    end
  end

  assign match      = (word == TRAINING_PATTERN);
  assign match_done = match && (match_cnt == MC_W'(MATCH_COUNT - 1));

  // Consecutive-match counter; a mismatch restarts it, and it saturates at MATCH_COUNT.
  always_ff @(posedge clk) begin
    if (usr_reset || clear) begin
      match_cnt <= '0;
    end else if (enable) begin
      if (!match) begin
        match_cnt <= '0;
      end else if (match_cnt != MC_W'(MATCH_COUNT)) begin
        match_cnt <= match_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lvds_word_align_ctrl.sv
// lvds_word_align_ctrl: walks the LVDS rx channels one at a time, issuing
// bitslip pulses until each channel shows the training word for MATCH_COUNT
// consecutive cycles. Defining LVDS_ALIGN_SLIPCNT_EN adds the slip_count
// output recording how many slips each channel needed.
module lvds_word_align_ctrl
  import lvds_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DESER_FACTOR = 10,
  parameter logic [DESER_FACTOR-1:0] TRAINING_PATTERN = LVDS_DEFAULT_TRAINING_PATTERN,
  parameter int MATCH_COUNT = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int MAX_SLIPS = DESER_FACTOR
) (
  input  logic                                          clk,
  input  logic                                          usr_reset,
  input  logic                                          align_start,
  input  logic [NUM_CHANNELS*DESER_FACTOR-1:0]          rx_data,
  output logic [NUM_CHANNELS-1:0]                       rx_bitslip,
  output logic                                          busy,
  output logic                                          align_done,
  output logic                                          align_fail,
  output logic [NUM_CHANNELS-1:0]                       ch_aligned,
  output logic [$clog2(NUM_CHANNELS)-1:0]               fail_ch
`ifdef LVDS_ALIGN_SLIPCNT_EN
  ,
  output logic [NUM_CHANNELS*$clog2(MAX_SLIPS+1)-1:0]   slip_count
`endif
);

  localparam int CH_W = $clog2(NUM_CHANNELS);
  localparam int SC_W = $clog2(MAX_SLIPS + 1);
  localparam int ST_W = $clog2(SETTLE_CYCLES + 1);

  align_state_t              state, state_n;
  logic [CH_W-1:0]           ch_idx, ch_idx_n;
  logic [SC_W-1:0]           slip_cnt, slip_cnt_n;
  logic [ST_W-1:0]           settle_cnt, settle_cnt_n;
  logic                      busy_n, done_n, fail_n;
  logic [NUM_CHANNELS-1:0]   ch_aligned_n, bitslip_n;
  logic [CH_W-1:0]           fail_ch_n;
  logic                      match_clear, match_en;
  logic                      match, match_done;
`ifdef LVDS_ALIGN_SLIPCNT_EN
  logic [NUM_CHANNELS*SC_W-1:0] slip_count_n;
`endif

  lvds_word_match #(
    .NUM_CHANNELS     (NUM_CHANNELS),
    .DESER_FACTOR     (DESER_FACTOR),
    .TRAINING_PATTERN (TRAINING_PATTERN),
    .MATCH_COUNT      (MATCH_COUNT)
  ) u_match (
    .clk        (clk),
    .usr_reset  (usr_reset),
    .clear      (match_clear),
    .enable     (match_en),
    .ch_idx     (ch_idx),
    .rx_data    (rx_data),
    .match      (match),
    .match_done (match_done)
  );

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_n      = state;
    ch_idx_n     = ch_idx;
    slip_cnt_n   = slip_cnt;
    settle_cnt_n = settle_cnt;
    done_n       = align_done;
    fail_n       = align_fail;
    fail_ch_n    = fail_ch;
    ch_aligned_n = ch_aligned;
    bitslip_n    = '0;
    match_clear  = 1'b0;
    match_en     = 1'b0;
`ifdef LVDS_ALIGN_SLIPCNT_EN
    slip_count_n = slip_count;
`endif
    case (state)
      IDLE, DONE, FAIL: begin
        if (align_start) begin
          ch_aligned_n = '0;
          done_n       = 1'b0;
          fail_n       = 1'b0;
          fail_ch_n    = '0;
          ch_idx_n     = '0;
          slip_cnt_n   = '0;
          settle_cnt_n = '0;
`ifdef LVDS_ALIGN_SLIPCNT_EN
          slip_count_n = '0;
`endif
          state_n      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == ST_W'(SETTLE_CYCLES - 1)) begin
          settle_cnt_n = '0;
          match_clear  = 1'b1;
          state_n      = CHECK;
        end else begin
          settle_cnt_n = settle_cnt + 1'b1;
        end
      end
      CHECK: begin
        match_en = 1'b1;
        if (!match) begin
          state_n = SLIP;
          if (slip_cnt != SC_W'(MAX_SLIPS)) begin
            bitslip_n = NUM_CHANNELS'(1) << ch_idx;
          end
        end else if (match_done) begin
          ch_aligned_n[ch_idx] = 1'b1;
          state_n              = NEXT;
        end
      end
      SLIP: begin
        if (slip_cnt == SC_W'(MAX_SLIPS)) begin
          fail_n    = 1'b1;
          fail_ch_n = ch_idx;
`ifdef LVDS_ALIGN_SLIPCNT_EN
          slip_count_n[ch_idx*SC_W +: SC_W] = slip_cnt;
`endif
          state_n   = FAIL;
        end else begin
          slip_cnt_n   = slip_cnt + 1'b1;
          settle_cnt_n = '0;
          state_n      = SETTLE;
        end
      end
      NEXT: begin
`ifdef LVDS_ALIGN_SLIPCNT_EN
        slip_count_n[ch_idx*SC_W +: SC_W] = slip_cnt;
`endif
        if (ch_idx == CH_W'(NUM_CHANNELS - 1)) begin
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          ch_idx_n     = ch_idx + 1'b1;
          slip_cnt_n   = '0;
          settle_cnt_n = '0;
          state_n      = SETTLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = !(state_n inside {IDLE, DONE, FAIL});
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (usr_reset) begin
      state      <= IDLE;
      ch_idx     <= '0;
      slip_cnt   <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      align_done <= 1'b0;
      align_fail <= 1'b0;
      fail_ch    <= '0;
      ch_aligned <= '0;
      rx_bitslip <= '0;
`ifdef LVDS_ALIGN_SLIPCNT_EN
      slip_count <= '0;
`endif
    end else begin
      state      <= state_n;
      ch_idx     <= ch_idx_n;
      slip_cnt   <= slip_cnt_n;
      settle_cnt <= settle_cnt_n;
      busy       <= busy_n;
      align_done <= done_n;
      align_fail <= fail_n;
      fail_ch    <= fail_ch_n;
      ch_aligned <= ch_aligned_n;
      rx_bitslip <= bitslip_n;
`ifdef LVDS_ALIGN_SLIPCNT_EN
      slip_count <= slip_count_n;
`endif
    end
  end

endmodule

// File: tb/tb_lvds_word_align_ctrl.sv
// Directed bench for lvds_word_align_ctrl. Each channel is modelled as a
// training word that rotates left by one bit per bitslip pulse.
module tb_lvds_word_align_ctrl;

  logic        clk = 1'b0;
  logic        usr_reset;
  logic        align_start;
  logic [39:0] rx_data;
  logic [3:0]  rx_bitslip;
  logic        busy;
  logic        align_done;
  logic        align_fail;
  logic [3:0]  ch_aligned;
  logic [1:0]  fail_ch;
`ifdef LVDS_ALIGN_SLIPCNT_EN
  logic [15:0] slip_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [9:0] init_word [4];
  logic [3:0] rot_en;
  int         slips [4];
  int         pulses [4];
  logic       multi_hot;
  int         cyc = 0;
  int         last_pulse;
  int         min_gap;
  logic       model_clr;
  logic       glitch;

  lvds_word_align_ctrl dut (
    .clk         (clk),
    .usr_reset   (usr_reset),
    .align_start (align_start),
    .rx_data     (rx_data),
    .rx_bitslip  (rx_bitslip),
    .busy        (busy),
    .align_done  (align_done),
    .align_fail  (align_fail),
    .ch_aligned  (ch_aligned),
    .fail_ch     (fail_ch)
`ifdef LVDS_ALIGN_SLIPCNT_EN
    ,
    .slip_count  (slip_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] rotl(input logic [9:0] w, input int n);
    logic [9:0] r;
    r = w;
    for (int i = 0; i < n % 10; i++) r = {r[8:0], r[9]};
    return r;
  endfunction

  // Channel model: rotate the word on each bitslip, track pulse counts and spacing.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (model_clr) begin
      for (int c = 0; c < 4; c++) begin
        slips[c]  <= 0;
        pulses[c] <= 0;
      end
      multi_hot  <= 1'b0;
      last_pulse <= -1;
      min_gap    <= 1000;
    end else begin
      if ($countones(rx_bitslip) > 1) multi_hot <= 1'b1;
      if (|rx_bitslip) begin
        if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap <= cyc - last_pulse;
        last_pulse <= cyc;
      end
      for (int c = 0; c < 4; c++) begin
        if (rx_bitslip[c]) begin
          pulses[c] <= pulses[c] + 1;
          if (rot_en[c]) slips[c] <= slips[c] + 1;
        end
      end
    end
  end

  // Channel words as seen by the receiver, with an optional bad word on channel 0.
  always_comb begin
    rx_data = '0;
    for (int c = 0; c < 4; c++) begin
      rx_data[c*10 +: 10] = (glitch && c == 0) ? 10'h000 : rotl(init_word[c], slips[c]);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic configure(input logic [9:0] w0, input logic [9:0] w1,
                           input logic [9:0] w2, input logic [9:0] w3, input logic [3:0] en);
    @(negedge clk);
    init_word[0] = w0;
    init_word[1] = w1;
    init_word[2] = w2;
    init_word[3] = w3;
    rot_en       = en;
    model_clr    = 1'b1;
    @(negedge clk);
    model_clr    = 1'b0;
  endtask

  task automatic pulseStart();
    @(negedge clk);
    align_start = 1'b1;
    @(negedge clk);
    align_start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [9:0] w0, input logic [9:0] w1,
                               input logic [9:0] w2, input logic [9:0] w3, input logic [3:0] en);
    configure(w0, w1, w2, w3, en);
    pulseStart();
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, busy, 0);
  endtask

  task automatic checkSpacing(input string tag);
    checkOutput({tag, "_onehot"}, multi_hot, 0);
    checkOutput({tag, "_gap"}, min_gap >= 9, 1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    usr_reset   = 1'b1;
    align_start = 1'b0;
    glitch      = 1'b0;
    model_clr   = 1'b1;
    rot_en      = 4'hF;
    for (int c = 0; c < 4; c++) init_word[c] = 10'h3E0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", align_done, 0);
    checkOutput("rst_fail", align_fail, 0);
    checkOutput("rst_aligned", ch_aligned, 0);
    checkOutput("rst_fail_ch", fail_ch, 0);
    checkOutput("rst_bitslip", rx_bitslip, 0);
`ifdef LVDS_ALIGN_SLIPCNT_EN
    checkOutput("rst_slip_count", slip_count, 0);
`endif
    usr_reset = 1'b0;

    $display("[TB] test 1: all channels aligned");
    applyStimulus(10'h3E0, 10'h3E0, 10'h3E0, 10'h3E0, 4'hF);
    checkOutput("t1_busy", busy, 1);
    repeat (99) @(negedge clk);
    checkOutput("t1_done_early", align_done, 0);
    @(negedge clk);
    checkOutput("t1_done", align_done, 1);
    checkOutput("t1_busy_low", busy, 0);
    checkOutput("t1_aligned", ch_aligned, 4'hF);
    checkOutput("t1_fail", align_fail, 0);
    checkOutput("t1_pulses", pulses[0] + pulses[1] + pulses[2] + pulses[3], 0);

    $display("[TB] test 2: channel 2 needs 3 slips");
    applyStimulus(10'h3E0, 10'h3E0, rotl(10'h3E0, 7), 10'h3E0, 4'hF);
    waitIdle("t2_idle", 1000);
    checkOutput("t2_pulses2", pulses[2], 3);
    checkOutput("t2_pulses_other", pulses[0] + pulses[1] + pulses[3], 0);
    checkOutput("t2_done", align_done, 1);
    checkOutput("t2_fail", align_fail, 0);
    checkOutput("t2_aligned", ch_aligned, 4'hF);
    checkSpacing("t2");
`ifdef LVDS_ALIGN_SLIPCNT_EN
    checkOutput("t2_slip_count", slip_count, 16'h0300);
`endif

    $display("[TB] test 3: channel 1 never matches");
    applyStimulus(10'h3E0, 10'h000, 10'h3E0, 10'h3E0, 4'hF);
    waitIdle("t3_idle", 2000);
    checkOutput("t3_pulses1", pulses[1], 10);
    checkOutput("t3_pulses_other", pulses[0] + pulses[2] + pulses[3], 0);
    checkOutput("t3_fail", align_fail, 1);
    checkOutput("t3_fail_ch", fail_ch, 1);
    checkOutput("t3_aligned", ch_aligned, 4'b0001);
    checkOutput("t3_done", align_done, 0);
    checkSpacing("t3");
`ifdef LVDS_ALIGN_SLIPCNT_EN
    checkOutput("t3_slip_count", slip_count, 16'h00A0);
`endif

    $display("[TB] test 4: channel 0 glitch on 16th word");
    configure(10'h3E0, 10'h3E0, 10'h3E0, 10'h3E0, 4'b1110);
    pulseStart();
    repeat (23) @(negedge clk);
    glitch = 1'b1;
    @(negedge clk);
    glitch = 1'b0;
    checkOutput("t4_no_early_align", ch_aligned, 0);
    checkOutput("t4_slip_pulse", rx_bitslip, 4'b0001);
    repeat (24) @(negedge clk);
    checkOutput("t4_align_early", ch_aligned, 0);
    @(negedge clk);
    checkOutput("t4_align_ch0", ch_aligned, 4'b0001);
    repeat (75) @(negedge clk);
    checkOutput("t4_done_early", align_done, 0);
    @(negedge clk);
    checkOutput("t4_done", align_done, 1);
    checkOutput("t4_pulses", pulses[0] + pulses[1] + pulses[2] + pulses[3], 1);

    $display("[TB] test 5: reset during SLIP, start held while busy");
    applyStimulus(10'h3E0, 10'h000, 10'h3E0, 10'h3E0, 4'hF);
    n = 0;
    while (!rx_bitslip[1] && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5_slip_seen", rx_bitslip, 4'b0010);
    usr_reset = 1'b1;
    @(negedge clk);
    checkOutput("t5_rst_bitslip", rx_bitslip, 0);
    checkOutput("t5_rst_busy", busy, 0);
    checkOutput("t5_rst_aligned", ch_aligned, 0);
    checkOutput("t5_rst_done", align_done, 0);
    checkOutput("t5_rst_fail", align_fail, 0);
    checkOutput("t5_rst_fail_ch", fail_ch, 0);
`ifdef LVDS_ALIGN_SLIPCNT_EN
    checkOutput("t5_rst_slip_count", slip_count, 0);
`endif
    usr_reset = 1'b0;
    configure(10'h3E0, 10'h3E0, 10'h3E0, 10'h3E0, 4'hF);
    @(negedge clk);
    align_start = 1'b1;
    repeat (31) @(negedge clk);
    checkOutput("t5_hold_aligned", ch_aligned, 4'b0001);
    checkOutput("t5_hold_busy", busy, 1);
    align_start = 1'b0;
    repeat (69) @(negedge clk);
    checkOutput("t5_done_early", align_done, 0);
    @(negedge clk);
    checkOutput("t5_done", align_done, 1);

    $display("[TB] test 6: restart from DONE");
    pulseStart();
    checkOutput("t6_aligned_clr", ch_aligned, 0);
    checkOutput("t6_done_clr", align_done, 0);
    checkOutput("t6_busy", busy, 1);
    waitIdle("t6_idle", 1000);
    checkOutput("t6_done", align_done, 1);
    checkOutput("t6_aligned", ch_aligned, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
